// File: rtl/mouse_bus_fifo_wrapper.sv
// Bus peripheral that queues mouse packets for the 8-bit CPU bus.
// Provides a 5-byte register window with control/info, software pop, sticky overflow and an interrupt.
module mouse_bus_fifo_wrapper #(
    parameter logic [7:0] BASE_ADDR  = 8'hA0,
    parameter int         DEPTH_LOG2 = 3,
    parameter int         STATUS_W   = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    inout  wire  [7:0]          BUS_DATA,
    input  logic [7:0]          BUS_ADDR,
    input  logic                BUS_WE,
    output logic                BUS_INTERRUPT_RAISE,
    input  logic                BUS_INTERRUPT_ACK,
    input  logic [STATUS_W-1:0] MOUSE_STATUS,
    input  logic [7:0]          MOUSE_X,
    input  logic [7:0]          MOUSE_Y,
    input  logic                MOUSE_VALID
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [STATUS_W-1:0]   status_mem [DEPTH];
    logic [7:0]            x_mem      [DEPTH];
    logic [7:0]            y_mem      [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  irq_en_q, irq_en_d;
    logic                  raise_q, raise_d;
    logic                  drive_q, drive_d;
    logic [7:0]            data_out_q, data_out_d;

    logic [7:0] offset;
    logic       in_win;
    logic       full, empty;
    logic       wr_ctrl, pop_req, clr_ovf;
    logic       do_push, do_pop;
    logic [7:0] head_status, head_x, head_y;
    logic       unused_ctrl_bits;

    assign offset  = BUS_ADDR - BASE_ADDR;
    assign in_win  = offset < 8'd5;
    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign wr_ctrl = BUS_WE && (offset == 8'd4);
    assign pop_req = wr_ctrl && BUS_DATA[1];
    assign clr_ovf = wr_ctrl && BUS_DATA[2];
    assign do_pop  = pop_req && !empty;
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign do_push = MOUSE_VALID && (!full || do_pop);
    assign unused_ctrl_bits = ^BUS_DATA[7:3];

    // The output enable is also gated by BUS_WE so the CPU never sees contention.
    assign BUS_DATA = (drive_q && !BUS_WE) ? data_out_q : 8'hzz;
    assign BUS_INTERRUPT_RAISE = raise_q;

    always_comb begin
        head_status = 8'h00;
        head_x      = 8'h00;
        head_y      = 8'h00;
        if (!empty) begin
            head_status[STATUS_W-1:0] = status_mem[rd_ptr_q];
            head_x                    = x_mem[rd_ptr_q];
            head_y                    = y_mem[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        irq_en_d   = irq_en_q;
        raise_d    = raise_q;
        drive_d    = 1'b0;
        data_out_d = data_out_q;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end

        if (MOUSE_VALID && !do_push) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        if (wr_ctrl) begin
            irq_en_d = BUS_DATA[0];
        end

        if (do_push && irq_en_q) begin
            raise_d = 1'b1;
        end else if (BUS_INTERRUPT_ACK) begin
            raise_d = 1'b0;
        end

        if (!BUS_WE && in_win) begin
            drive_d = 1'b1;
            case (offset[2:0])
                3'd0:    data_out_d = head_status;
                3'd1:    data_out_d = head_x;
                3'd2:    data_out_d = head_y;
                3'd3:    data_out_d = {ovf_q, full, empty, 5'(count_q)};
                default: data_out_d = {7'b0, irq_en_q};
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            raise_q    <= 1'b0;
            drive_q    <= 1'b0;
            data_out_q <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            irq_en_q   <= irq_en_d;
            raise_q    <= raise_d;
            drive_q    <= drive_d;
            data_out_q <= data_out_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET && do_push) begin
            status_mem[wr_ptr_q] <= MOUSE_STATUS;
            x_mem[wr_ptr_q]      <= MOUSE_X;
            y_mem[wr_ptr_q]      <= MOUSE_Y;
        end
    end

endmodule

// File: tb/tb_mouse_bus_fifo_wrapper.sv
// Scoreboard bench for mouse_bus_fifo_wrapper: packets queued on push, compared on head reads before pop.
module tb_mouse_bus_fifo_wrapper;

    localparam logic [7:0] BASE = 8'hA0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] addr;
    logic       we;
    logic       ack;
    logic [3:0] ms;
    logic [7:0] mx, my;
    logic       mv;
    logic       raise;
    logic       tb_drv;
    logic [7:0] tb_wdata;
    wire  [7:0] bus_data;

    always #5 clk = ~clk;

    assign bus_data = tb_drv ? tb_wdata : 8'hzz;

    // Released bus floats high, so a read of 8'hFF means nobody drives it.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pu
        pullup (bus_data[gi]);
    end

    mouse_bus_fifo_wrapper #(
        .BASE_ADDR (BASE),
        .DEPTH_LOG2(3),
        .STATUS_W  (4)
    ) dut (
        .CLK                (clk),
        .RESET              (rst_n),
        .BUS_DATA           (bus_data),
        .BUS_ADDR           (addr),
        .BUS_WE             (we),
        .BUS_INTERRUPT_RAISE(raise),
        .BUS_INTERRUPT_ACK  (ack),
        .MOUSE_STATUS       (ms),
        .MOUSE_X            (mx),
        .MOUSE_Y            (my),
        .MOUSE_VALID        (mv)
    );

    typedef struct packed {
        logic [3:0] s;
        logic [7:0] x;
        logic [7:0] y;
    } pkt_t;

    pkt_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   m_ovf, m_irq, m_raise;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_info();
        int n;
        n = sb.size();
        return {m_ovf, n == 8, n == 0, 5'(n)};
    endfunction

    task automatic step(input bit push, input pkt_t p, input bit wr, input logic [7:0] wd, input bit ak);
        bit pop_ok, push_ok;
        @(negedge clk);
        mv  = push;
        {ms, mx, my} = p;
        ack = ak;
        if (wr) begin
            addr     = BASE + 8'd4;
            we       = 1'b1;
            tb_drv   = 1'b1;
            tb_wdata = wd;
        end
        pop_ok  = wr && wd[1] && (sb.size() > 0);
        push_ok = push && ((sb.size() < 8) || pop_ok);
        if (pop_ok) void'(sb.pop_front());
        if (push_ok) sb.push_back(p);
        if (push && !push_ok) m_ovf = 1'b1;
        else if (wr && wd[2]) m_ovf = 1'b0;
        if (push_ok && m_irq) m_raise = 1'b1;
        else if (ak) m_raise = 1'b0;
        if (wr) m_irq = wd[0];
        @(posedge clk);
        #1;
        mv     = 1'b0;
        we     = 1'b0;
        tb_drv = 1'b0;
        addr   = 8'h00;
        ack    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] off, output logic [7:0] d);
        @(negedge clk);
        addr = BASE + 8'(off);
        we   = 1'b0;
        @(posedge clk);
        #1;
        d    = bus_data;
        addr = 8'h00;
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] off, input logic [7:0] exp);
        logic [7:0] d;
        rd(off, d);
        chk(tag, d, exp);
    endtask

    task automatic chk_head(input string tag);
        pkt_t h;
        h = (sb.size() > 0) ? sb[0] : '0;
        chk({tag, ".s"}, 8'(0), 8'(0));
        chk_reg({tag, ".s"}, 3'd0, {4'h0, h.s});
        chk_reg({tag, ".x"}, 3'd1, h.x);
        chk_reg({tag, ".y"}, 3'd2, h.y);
    endtask

    task automatic pop_one(input string tag);
        chk_head(tag);
        step(1'b0, '0, 1'b1, {7'b0000001, m_irq}, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        m_ovf   = 1'b0;
        m_irq   = 1'b0;
        m_raise = 1'b0;
    endtask

    pkt_t last_pkt;

    initial begin
        rst_n = 1'b1; addr = 8'h00; we = 1'b0; ack = 1'b0;
        ms = '0; mx = '0; my = '0; mv = 1'b0; tb_drv = 1'b0; tb_wdata = '0;

        // reset state
        do_reset();
        chk("rst.raise", {7'b0, raise}, 8'h00);
        chk_reg("rst.info", 3'd3, 8'h20);
        chk_reg("rst.head", 3'd0, 8'h00);
        chk_reg("rst.ctrl", 3'd4, 8'h00);

        // single push, interrupts disabled
        step(1'b1, {4'h9, 8'h12, 8'hF0}, 1'b0, 8'h00, 1'b0);
        chk_head("p1");
        chk_reg("p1.info", 3'd3, 8'h01);
        chk("p1.raise", {7'b0, raise}, 8'h00);

        // interrupt raise, ack, ack coincident with push, hold across IRQ_EN clear
        step(1'b0, '0, 1'b1, 8'h01, 1'b0);
        chk_reg("irq.ctrl", 3'd4, 8'h01);
        step(1'b1, {4'h3, 8'h44, 8'h55}, 1'b0, 8'h00, 1'b0);
        chk("irq.set", {7'b0, raise}, 8'h01);
        step(1'b0, '0, 1'b0, 8'h00, 1'b1);
        chk("irq.ack", {7'b0, raise}, 8'h00);
        step(1'b1, {4'h6, 8'h66, 8'h77}, 1'b0, 8'h00, 1'b1);
        chk("irq.ackpush", {7'b0, raise}, 8'h01);
        chk_reg("irq.info", 3'd3, m_info());
        step(1'b0, '0, 1'b1, 8'h00, 1'b0);
        chk("irq.hold", {7'b0, raise}, {7'b0, m_raise});
        while (sb.size() > 0) pop_one("drain1");
        chk_reg("drain1.info", 3'd3, 8'h20);
        step(1'b0, '0, 1'b0, 8'h00, 1'b1);
        chk("irq.clr", {7'b0, raise}, 8'h00);

        // overflow on the ninth packet, then clear
        for (int i = 0; i < 9; i++)
            step(1'b1, {4'(i), 8'(8'h30 + i), 8'(8'h50 + i)}, 1'b0, 8'h00, 1'b0);
        chk_reg("ovf.info", 3'd3, 8'hC8);
        chk_reg("ovf.model", 3'd3, m_info());
        step(1'b0, '0, 1'b1, 8'h04, 1'b0);
        chk_reg("ovf.clr", 3'd3, 8'h48);

        // full FIFO: push and pop together keep COUNT, advance head
        for (int i = 0; i < 3; i++) begin
            chk_head("pp");
            last_pkt = {4'(4'hA + i), 8'(8'hC0 + i), 8'(8'hE0 + i)};
            step(1'b1, last_pkt, 1'b1, 8'h02, 1'b0);
            chk_reg("pp.info", 3'd3, 8'h48);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("pp.newest", {4'h0, sb[0].s}, {4'h0, last_pkt.s});
            pop_one("drain2");
        end
        chk_reg("drain2.info", 3'd3, 8'h20);

        // pop on empty, outside-window read, bus release
        step(1'b0, '0, 1'b1, 8'h02, 1'b0);
        chk_reg("popempty.info", 3'd3, 8'h20);
        @(posedge clk);
        #1;
        chk("release", bus_data, 8'hFF);
        @(negedge clk);
        addr = 8'hA5;
        we   = 1'b0;
        @(posedge clk);
        #1;
        chk("oow", bus_data, 8'hFF);
        addr = 8'h00;

        // reset with packets queued and interrupt pending
        step(1'b0, '0, 1'b1, 8'h01, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, {4'(i + 1), 8'(8'h70 + i), 8'(8'h90 + i)}, 1'b0, 8'h00, 1'b0);
        chk_reg("pre.info", 3'd3, 8'h03);
        chk("pre.raise", {7'b0, raise}, 8'h01);
        do_reset();
        chk_reg("rst2.info", 3'd3, 8'h20);
        chk_reg("rst2.ctrl", 3'd4, 8'h00);
        chk("rst2.raise", {7'b0, raise}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
